// File: rtl/fetch_unit_pkg.sv
// Shared processor constants so the core and the fetch stage agree on reset
// vectors, the bubble encoding and opcode values.
package proc_pkg;

  localparam int          ARCH_BITS       = 32;
  localparam logic [31:0] PC_RST          = 32'h0000_1000;
  localparam logic [31:0] PC_EXCEPT       = 32'h0000_0100;
  localparam logic [31:0] NOP_INSTRUCTION = 32'hFFFF_FFFF;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Generic synchronous FIFO with a flush input; used as the fetch buffer
// holding {pc, inst} pairs between icache and decode.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         headData,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic             full;
  logic             doPush;
  logic             doPop;

  assign full     = (count == CNT_W'(DEPTH));
  assign doPush   = push && !full && !flush;
  assign doPop    = pop && (count != '0) && !flush;
  assign headData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush && !rst) mem[wrPtr] <= pushData;
  end

  // Pointers are PTR_W wide so they wrap on their own at DEPTH.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: sequences the fetch PC, buffers icache hits
// with their PCs and hands them to decode under a valid/stall handshake.
module fetch_unit #(
  parameter int                  ARCH_BITS       = proc_pkg::ARCH_BITS,
  parameter logic [ARCH_BITS-1:0] PC_RST         = proc_pkg::PC_RST,
  parameter int                  QUEUE_DEPTH     = 4,
  parameter logic [ARCH_BITS-1:0] NOP_INSTRUCTION = proc_pkg::NOP_INSTRUCTION
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [ARCH_BITS-1:0]         icAddr,
  output logic                         icReq,
  input  logic [ARCH_BITS-1:0]         icInst,
  input  logic                         icValid,
  input  logic                         redirect,
  input  logic [ARCH_BITS-1:0]         redirectPc,
  input  logic                         decStall,
  output logic                         decValid,
  output logic [ARCH_BITS-1:0]         decInst,
  output logic [ARCH_BITS-1:0]         decPc,
  output logic [$clog2(QUEUE_DEPTH):0] queueCount
);

  import proc_pkg::*;

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic [ARCH_BITS-1:0]   fetchPc;
  logic [2*ARCH_BITS-1:0] headEntry;
  logic                   queueFull;
  logic                   push;
  logic                   pop;

  assign queueFull = (queueCount == CNT_W'(QUEUE_DEPTH));
  assign icAddr    = fetchPc;
  assign icReq     = !rst && !redirect && !queueFull;
  assign push      = icReq && icValid;
  assign decValid  = (queueCount != '0) && !redirect;
  assign pop       = decValid && !decStall;
  assign decPc     = decValid ? headEntry[2*ARCH_BITS-1:ARCH_BITS] : '0;
  assign decInst   = decValid ? headEntry[ARCH_BITS-1:0] : NOP_INSTRUCTION;

  // Reset beats redirect, redirect beats sequential advance; a miss holds
  // the PC so the same address is re-requested next cycle.
  always_ff @(posedge clk) begin
    if (rst)
      fetchPc <= PC_RST;
    else if (redirect)
      fetchPc <= {redirectPc[ARCH_BITS-1:2], 2'b00};
    else if (push)
      fetchPc <= fetchPc + ARCH_BITS'(4);
  end

  fetch_fifo #(
    .WIDTH (2*ARCH_BITS),
    .DEPTH (QUEUE_DEPTH)
  ) fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect),
    .push     (push),
    .pushData ({fetchPc, icInst}),
    .pop      (pop),
    .headData (headEntry),
    .count    (queueCount)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a queue-of-entries reference model plus a
// negedge monitor comparing every DUT output against it.
module tb_fetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] NOP    = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] icAddr;
  logic        icReq;
  logic [31:0] icInst;
  logic        icValid;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        decStall;
  logic        decValid;
  logic [31:0] decInst;
  logic [31:0] decPc;
  logic [2:0]  queueCount;

  fetch_unit #(
    .ARCH_BITS       (32),
    .PC_RST          (RST_PC),
    .QUEUE_DEPTH     (DEPTH),
    .NOP_INSTRUCTION (NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .icAddr     (icAddr),
    .icReq      (icReq),
    .icInst     (icInst),
    .icValid    (icValid),
    .redirect   (redirect),
    .redirectPc (redirectPc),
    .decStall   (decStall),
    .decValid   (decValid),
    .decInst    (decInst),
    .decPc      (decPc),
    .queueCount (queueCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t      expQ[$];
  logic [31:0] mPc = RST_PC;
  int          checkCount = 0;
  int          passCount = 0;
  bit          monitorOn = 1'b0;
  bit          pendRst = 1'b0;
  bit          pendRedir = 1'b0;
  bit          pendPush = 1'b0;
  logic [31:0] pendRedirPc = '0;
  logic [31:0] pendInst = '0;

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Apply what the model decided for the cycle that just ended.
  task automatic commitModel();
    if (pendRst) begin
      mPc = RST_PC;
      expQ.delete();
    end else if (pendRedir) begin
      mPc = pendRedirPc & 32'hFFFF_FFFC;
      expQ.delete();
    end else if (pendPush) begin
      expQ.push_back('{pc: mPc, inst: pendInst});
      mPc = mPc + 32'd4;
    end
    pendRst   = 1'b0;
    pendRedir = 1'b0;
    pendPush  = 1'b0;
  endtask

  task automatic applyStimulus(input bit r, input bit rd, input logic [31:0] rpc,
                               input bit st, input bit v);
    @(posedge clk);
    #1;
    commitModel();
    rst        = r;
    redirect   = rd;
    redirectPc = rpc;
    decStall   = st;
    icValid    = v;
    icInst     = $urandom();
    monitorOn  = 1'b1;
  endtask

  task automatic checkOutput();
    bit expReq;
    bit expValid;
    expReq   = !rst && !redirect && (expQ.size() < DEPTH);
    expValid = (expQ.size() != 0) && !redirect;
    compare("icAddr", icAddr, mPc);
    compare("icReq", {31'd0, icReq}, {31'd0, expReq});
    compare("decValid", {31'd0, decValid}, {31'd0, expValid});
    compare("queueCount", {29'd0, queueCount}, 32'(expQ.size()));
    if (expValid) begin
      compare("decPc", decPc, expQ[0].pc);
      compare("decInst", decInst, expQ[0].inst);
      if (!decStall) void'(expQ.pop_front());
    end else begin
      compare("decPcIdle", decPc, 32'd0);
      compare("decInstIdle", decInst, NOP);
    end
    pendRst     = rst;
    pendRedir   = redirect;
    pendRedirPc = redirectPc;
    pendPush    = expReq && icValid;
    pendInst    = icInst;
  endtask

  always @(negedge clk) begin
    if (monitorOn) checkOutput();
  end

  initial begin
    rst        = 1'b1;
    redirect   = 1'b0;
    redirectPc = '0;
    decStall   = 1'b0;
    icValid    = 1'b0;
    icInst     = '0;

    repeat (2) applyStimulus(1, 0, 32'h0, 0, 1);
    repeat (8) applyStimulus(0, 0, 32'h0, 0, 1);
    repeat (6) applyStimulus(0, 0, 32'h0, 1, 1);
    repeat (6) applyStimulus(0, 0, 32'h0, 0, 1);
    repeat (3) applyStimulus(0, 0, 32'h0, 0, 0);
    repeat (4) applyStimulus(0, 0, 32'h0, 0, 1);
    repeat (3) applyStimulus(0, 0, 32'h0, 1, 1);
    applyStimulus(0, 1, 32'h0000_2002, 0, 1);
    repeat (4) applyStimulus(0, 0, 32'h0, 0, 1);
    repeat (6) applyStimulus(0, 0, 32'h0, 1, 1);
    applyStimulus(0, 1, 32'h0000_2000, 0, 1);
    repeat (4) applyStimulus(0, 0, 32'h0, 0, 1);
    applyStimulus(0, 1, 32'h0000_4000, 0, 1);
    applyStimulus(0, 1, 32'h0000_5004, 0, 1);
    repeat (3) applyStimulus(0, 0, 32'h0, 0, 1);
    applyStimulus(1, 1, 32'h0000_3000, 0, 1);
    repeat (3) applyStimulus(0, 0, 32'h0, 0, 1);
    applyStimulus(0, 1, 32'hFFFF_FFF9, 0, 1);
    repeat (5) applyStimulus(0, 0, 32'h0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      bit          r;
      bit          rd;
      bit          st;
      bit          v;
      logic [31:0] rpc;
      r   = ($urandom_range(63) == 0);
      rd  = ($urandom_range(9) == 0);
      st  = ($urandom_range(2) == 0);
      v   = ($urandom_range(2) != 0);
      rpc = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
      applyStimulus(r, rd, rpc, st, v);
    end

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised, decoupled instruction-fetch stage for the pipelined core. It owns the fetch PC and drives the instruction cache. It buffers returned instructions with their PCs in a QUEUE_DEPTH-entry queue, so that icache misses and decode stalls are absorbed independently. It presents a valid/stall handshake to decode and flushes cleanly on a taken-branch redirect from the ALU stage.

## Interface
Parameters:
- ARCH_BITS, 32: PC and instruction width.
- PC_RST, 32'h00001000: fetch PC after reset.
- QUEUE_DEPTH, 4: queue entries. Must be a power of two, ≥2.
- NOP_INSTRUCTION, 32'hFFFFFFFF: value driven on decInst when decValid=0.

Ports:
- clk  in  1  rising-edge clock. Single clock domain.
- rst  in  1  synchronous, active-high reset.
- icAddr  out  ARCH_BITS  fetch PC presented to icache.
- icReq  out  1  fetch request. The icache result is consumed only when icReq=1.
- icInst  in  ARCH_BITS  instruction for icAddr. Same-cycle response.
- icValid  in  1  icInst valid this cycle (hit).
- redirect  in  1  taken branch/jump; flush and refetch.
- redirectPc  in  ARCH_BITS  new fetch PC. Bits [1:0] are forced to 0.
- decStall  in  1  decode cannot accept this cycle.
- decValid  out  1  decInst/decPc hold a real instruction.
- decInst  out  ARCH_BITS  head-of-queue instruction, or NOP_INSTRUCTION.
- decPc  out  ARCH_BITS  head-of-queue PC, 0 when invalid.
- queueCount  out  $clog2(QUEUE_DEPTH)+1  occupied entries.

## Operation
- State: fetchPc register; queue of {pc, inst} entries with rdPtr/wrPtr of $clog2(QUEUE_DEPTH) bits that wrap naturally; count register.
- icAddr = fetchPc. icReq = !rst && !redirect && (count < QUEUE_DEPTH).
- Push: icReq && icValid. Writes {fetchPc, icInst} at wrPtr, then wrPtr+1 and fetchPc+4. Arithmetic is mod 2^ARCH_BITS; 32'hFFFFFFFC wraps to 0.
- A miss (icValid=0) leaves fetchPc unchanged; the request is repeated every cycle until a hit.
- Pop: decValid && !decStall. Advances rdPtr.
- decValid = (count != 0) && !redirect.
- decInst/decPc show the head entry when decValid=1; otherwise NOP_INSTRUCTION/0.
- count update: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Full (count == QUEUE_DEPTH): icReq=0 and no push. There is no same-cycle full bypass, even if a pop occurs that cycle.
- Empty: decValid=0. There is no icache-to-decode bypass.
- Redirect (highest priority over push/pop) in cycle t:
  - no push and no pop in t;
  - at edge t+1: count←0, rdPtr←wrPtr←0, fetchPc←{redirectPc[ARCH_BITS-1:2], 2'b00}.
- Back-to-back redirects: the last one wins; each cycle reloads fetchPc.
- decStall has no effect on fetch except through queue occupancy.

## Timing
- Reset, at the first edge with rst=1: fetchPc=PC_RST, count=0, pointers=0.
- Outputs during and immediately after reset: decValid=0, decInst=NOP_INSTRUCTION, decPc=0, icReq=0 (while rst), icAddr=PC_RST, queueCount=0.
- rst asserted mid-operation: the queue is discarded at the next edge. A pending redirect is ignored; rst takes priority.
- Fetch-to-decode latency: a hit at edge t into an empty queue gives decValid=1 in cycle t+1.
- Throughput: one instruction per cycle with continuous hits and no stall.
- Redirect asserted in t:
  - first request to redirectPc in t+1;
  - earliest decValid for the new stream in t+2.
- All outputs are combinational functions of registered state plus redirect. There are no combinational paths from icValid or decStall to outputs.

## Structure
- Shared package proc_pkg holds ARCH_BITS, PC_RST, PC_EXCEPT, NOP_INSTRUCTION and the OPCODE_* constants, so core and fetch agree on values.
- One sub-module, fetch_fifo: a generic synchronous FIFO of width 2*ARCH_BITS and depth QUEUE_DEPTH, with a flush input. fetch_unit adds PC sequencing and the redirect/handshake logic.

## Test plan
- Reset then continuous hits, decStall=0 → icAddr 0x1000, 0x1004, 0x1008…; decPc follows one cycle later; decValid=1 from cycle 2 onward; queueCount stays 1.
- decStall=1 for 6 cycles with hits, QUEUE_DEPTH=4 → queueCount reaches 4; icReq=0 once full; fetchPc holds 0x1010; release → decPc 0x1000, 0x1004… with no gap or duplicate.
- icValid=0 for 3 cycles → icAddr held constant; decValid drops after the queue drains; the first post-miss instruction appears at t+1 of the hit.
- Redirect to 0x2002 with 3 entries queued → decValid=0 in the redirect cycle; queueCount=0 next cycle; icAddr=0x2000; old PCs never reach decode.
- Redirect coincident with full queue, hit and pop → no push, no pop counted; flush takes effect; decPc 0x2000 in t+2.
- rst pulsed mid-stream with redirect=1 → fetchPc=0x1000 (not the redirect target); all outputs at their reset values.
